crc_gen: RTL and testbench



---
 rtl/usb_pkg.sv | 33 +++
 rtl/crc_lfsr.sv | 37 +++
 rtl/crc_gen.sv | 150 +++++++++++++++
 tb/tb_crc_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB serial transmit path.
// Packet types, CRC polynomials/presets/residuals and packet sizes.
package usb_pkg;

    localparam logic [1:0] PKT_NONE   = 2'b00;
    localparam logic [1:0] PKT_TOKEN  = 2'b01;
    localparam logic [1:0] PKT_DATA   = 2'b11;
    localparam logic [1:0] PKT_HSHAKE = 2'b10;

    localparam int CRC5_W  = 5;
    localparam int CRC16_W = 16;

    localparam logic [CRC5_W-1:0] CRC5_POLY  = 5'b00101;
    localparam logic [CRC5_W-1:0] CRC5_INIT  = 5'b11111;
    localparam logic [CRC5_W-1:0] CRC5_RESID = 5'b01100;

    localparam logic [CRC16_W-1:0] CRC16_POLY  = 16'h8005;
    localparam logic [CRC16_W-1:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [CRC16_W-1:0] CRC16_RESID = 16'h800D;

    localparam int TOKEN_BITS  = 27;
    localparam int DATA_BITS   = 80;
    localparam int HSHAKE_BITS = 16;

    localparam int REM_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_CRC  = 2'd2
    } state_t;

endpackage

// File: rtl/crc_lfsr.sv
// Serial CRC shift register: preset, per-bit update, or plain shift-out.
// Preset wins over update, update wins over shift.
module crc_lfsr #(
    parameter int           W    = 5,
    parameter logic [W-1:0] POLY = '0,
    parameter logic [W-1:0] INIT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_bit,
    input  logic         i_shift,
    output logic         o_shift_out,
    output logic [W-1:0] o_crc
);

    logic [W-1:0] r_crc;
    logic         w_fb;

    assign w_fb        = i_bit ^ r_crc[W-1];
    assign o_shift_out = r_crc[W-1];
    assign o_crc       = r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= INIT;
        end else if (i_clr) begin
            r_crc <= INIT;
        end else if (i_en) begin
            r_crc <= {r_crc[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end else if (i_shift) begin
            r_crc <= {r_crc[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/crc_gen.sv
// Serial CRC generator: passes SYNC/PID/payload through, then appends
// the complemented CRC5 (token) or CRC16 (data) MSB-first.
module crc_gen
    import usb_pkg::*;
#(
    parameter int PID_BITS = 16,
    parameter int CNT_W    = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pkt_in,
    input  logic       s_in,
    input  logic       endr,
    output logic       s_out,
    output logic       s_valid,
    output logic       eop,
    output logic       busy
);

    localparam logic [CNT_W-1:0] PID_CNT = CNT_W'(PID_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state, w_nstate;
    logic [1:0]         r_type, w_type;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [REM_W-1:0]   r_rem, w_rem;
    logic               r_s_out, r_s_valid, r_eop;
    logic               w_s_out, w_s_valid, w_eop;
    logic               w_clr, w_en, w_shift;
    logic               w_is16, w_msb5, w_msb16, w_msb;
    logic [CRC5_W-1:0]  w_crc5;
    logic [CRC16_W-1:0] w_crc16;
    logic               w_unused_crc;

    assign w_is16       = (r_type == PKT_DATA);
    assign w_msb        = w_is16 ? w_msb16 : w_msb5;
    assign w_unused_crc = ^{w_crc5, w_crc16};

    crc_lfsr #(.W(CRC5_W), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_clr),
        .i_en        (w_en & (r_type == PKT_TOKEN)),
        .i_bit       (s_in),
        .i_shift     (w_shift & ~w_is16),
        .o_shift_out (w_msb5),
        .o_crc       (w_crc5)
    );

    crc_lfsr #(.W(CRC16_W), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_clr),
        .i_en        (w_en & w_is16),
        .i_bit       (s_in),
        .i_shift     (w_shift & w_is16),
        .o_shift_out (w_msb16),
        .o_crc       (w_crc16)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            ST_IDLE: if (pkt_in != PKT_NONE) w_nstate = ST_PASS;
            ST_PASS: if (endr) w_nstate = (r_type == PKT_HSHAKE) ? ST_IDLE : ST_CRC;
            ST_CRC:  if (r_rem == '0) w_nstate = ST_IDLE;
            default: w_nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        w_s_out   = 1'b0;
        w_s_valid = 1'b0;
        w_eop     = 1'b0;
        w_clr     = 1'b0;
        w_en      = 1'b0;
        w_shift   = 1'b0;
        w_cnt     = r_cnt;
        w_rem     = r_rem;
        w_type    = r_type;
        unique case (r_state)
            ST_IDLE: begin
                if (pkt_in != PKT_NONE) begin
                    w_clr  = 1'b1;
                    w_cnt  = '0;
                    w_type = pkt_in;
                end
            end
            ST_PASS: begin
                if (!endr) begin
                    w_s_out   = s_in;
                    w_s_valid = 1'b1;
                    w_cnt     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                    w_en      = (r_cnt >= PID_CNT);
                end else if (r_type == PKT_HSHAKE) begin
                    w_eop = 1'b1;
                end else begin
                    // First CRC bit goes out in the endr cycle so there is no gap.
                    w_s_out   = ~w_msb;
                    w_s_valid = 1'b1;
                    w_shift   = 1'b1;
                    w_rem     = w_is16 ? REM_W'(CRC16_W - 1) : REM_W'(CRC5_W - 1);
                end
            end
            ST_CRC: begin
                if (r_rem != '0) begin
                    w_s_out   = ~w_msb;
                    w_s_valid = 1'b1;
                    w_shift   = 1'b1;
                    w_rem     = r_rem - 1'b1;
                end else begin
                    w_eop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_type    <= PKT_NONE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_s_out   <= 1'b0;
            r_s_valid <= 1'b0;
            r_eop     <= 1'b0;
        end else begin
            r_type    <= w_type;
            r_cnt     <= w_cnt;
            r_rem     <= w_rem;
            r_s_out   <= w_s_out;
            r_s_valid <= w_s_valid;
            r_eop     <= w_eop;
        end
    end

    assign s_out   = r_s_out;
    assign s_valid = r_s_valid;
    assign eop     = r_eop;
    assign busy    = (r_state != ST_IDLE) | r_eop;

endmodule

// File: tb/tb_crc_gen.sv
// Scoreboard bench for crc_gen: driver queues the expected serial stream,
// a negedge monitor pops and compares every valid bit and eop.
module tb_crc_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pkt_in = 2'b00;
    logic       s_in = 1'b0;
    logic       endr = 1'b1;
    logic       s_out, s_valid, eop, busy;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    bit rx_bits[$];
    bit tx[0:127];

    always #5 clk = ~clk;

    crc_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pkt_in  (pkt_in),
        .s_in    (s_in),
        .endr    (endr),
        .s_out   (s_out),
        .s_valid (s_valid),
        .eop     (eop),
        .busy    (busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Polynomial division over message bits 16..n-1, preset all ones.
    function automatic int crc_of(input int w, input int n);
        int poly = (w == 5) ? 'h05 : 'h8005;
        int mask = (1 << w) - 1;
        int r = mask;
        for (int i = 16; i < n; i++) begin
            int fb = tx[i] ^ ((r >> (w - 1)) & 1);
            r = ((r << 1) & mask) ^ (fb != 0 ? poly : 0);
        end
        return r;
    endfunction

    function automatic int resid_of(input int w);
        int poly = (w == 5) ? 'h05 : 'h8005;
        int mask = (1 << w) - 1;
        int r = mask;
        for (int i = 16; i < rx_bits.size(); i++) begin
            int fb = rx_bits[i] ^ ((r >> (w - 1)) & 1);
            r = ((r << 1) & mask) ^ (fb != 0 ? poly : 0);
        end
        return r;
    endfunction

    function automatic int tail_of(input int w);
        int v = 0;
        int n = rx_bits.size();
        for (int i = n - w; i < n; i++) begin
            if (i >= 0) v = (v << 1) | int'(rx_bits[i]);
        end
        return v;
    endfunction

    // Monitor: 0/1 = data bit, 2 = eop marker, 3 = illegal valid+eop.
    always @(negedge clk) begin
        logic [31:0] g;
        if (rst_n && (s_valid || eop)) begin
            g = eop ? (s_valid ? 32'd3 : 32'd2) : {31'b0, s_out};
            if (s_valid) rx_bits.push_back(s_out);
            if (exp_q.size() == 0) chk("q_nonempty", exp_q.size(), 1);
            else chk("stream", g, exp_q.pop_front());
        end
    end

    task automatic run_pkt(input logic [1:0] t, input int n, input int abort_at, input bit stray);
        int w;
        int c;
        int cyc;
        rx_bits.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(int'(tx[i]));
        if (abort_at < 0) begin
            if (t != 2'b10) begin
                w = (t == 2'b11) ? 16 : 5;
                c = crc_of(w, n);
                for (int k = w - 1; k >= 0; k--) exp_q.push_back(((~c) >> k) & 1);
            end
            exp_q.push_back(2);
        end
        pkt_in = t;
        endr = 1'b0;
        @(posedge clk); #1;
        pkt_in = 2'b00;
        chk("busy_after_strobe", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outputs", {28'b0, s_out, s_valid, eop, busy}, 0);
                exp_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                endr = 1'b1;
                s_in = 1'b0;
                return;
            end
            s_in = tx[i];
            pkt_in = (stray && i == n / 2) ? 2'b01 : 2'b00;
            @(posedge clk); #1;
        end
        pkt_in = 2'b00;
        endr = 1'b1;
        s_in = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            pkt_in = (stray && cyc == 1) ? 2'b11 : 2'b00;
        end while (!eop && cyc < 40);
        pkt_in = 2'b00;
        chk("eop_seen", eop, 1);
        chk("busy_at_eop", busy, 1);
        @(posedge clk); #1;
        chk("busy_after_eop", busy, 0);
        chk("q_drained", exp_q.size(), 0);
    endtask

    task automatic fill(input int first, input int n, input bit zero);
        for (int i = first; i < n; i++) tx[i] = zero ? 1'b0 : 1'($urandom);
    endtask

    initial begin
        #3;
        chk("rst_s_out", s_out, 0);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_eop", eop, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        fill(0, 16, 0);
        fill(16, 27, 1);
        run_pkt(2'b01, 27, -1, 0);
        chk("tok_nvalid", rx_bits.size(), 32);
        chk("tok_crc_bits", tail_of(5), 5'b01000);
        chk("tok_resid", resid_of(5), 5'b01100);

        fill(0, 16, 0);
        run_pkt(2'b10, 16, -1, 0);
        chk("hs_nvalid", rx_bits.size(), 16);

        fill(0, 80, 0);
        run_pkt(2'b11, 80, -1, 1);
        chk("data_nvalid", rx_bits.size(), 96);
        chk("data_resid", resid_of(16), 16'h800D);

        fill(0, 80, 0);
        run_pkt(2'b11, 80, 40, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("post_abort_busy", busy, 0);

        fill(0, 27, 0);
        run_pkt(2'b01, 27, -1, 0);
        chk("tok2_nvalid", rx_bits.size(), 32);
        chk("tok2_resid", resid_of(5), 5'b01100);

        fill(0, 8, 0);
        run_pkt(2'b01, 8, -1, 0);
        chk("early_nvalid", rx_bits.size(), 13);
        chk("early_crc_bits", tail_of(5), 0);

        for (int p = 0; p < 8; p++) begin
            int sel = $urandom_range(0, 2);
            int n;
            logic [1:0] t;
            t = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b11 : 2'b10;
            n = (sel == 0) ? 27 : (sel == 1) ? 16 + 8 * $urandom_range(0, 8) : 16;
            fill(0, n, 0);
            run_pkt(t, n, -1, 1'($urandom_range(0, 1)) & (sel == 1));
            if (sel == 2) begin
                chk("rnd_hs_nvalid", rx_bits.size(), 16);
            end else begin
                chk("rnd_nvalid", rx_bits.size(), n + ((sel == 0) ? 5 : 16));
                chk("rnd_resid", resid_of((sel == 0) ? 5 : 16),
                    (sel == 0) ? 32'h0C : 32'h800D);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("final_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
